// File: rtl/mat_vec_loader.sv
// mat_vec_loader: streams a DEPTH x DEPTH matrix (row-major) followed by a
// DEPTH-element vector into per-row matrix FIFOs and a vector FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a load sequence (accepted only from IDLE)
//   in_valid/in_data  element stream; in_ready high while loading
//   busy, done        sequence in progress / one-cycle end pulse
//   Clr               active-low clear to the multiplier
//   a_wren/a_fifo_in  per-row matrix FIFO write enable / data
//   b_wren/b_fifo_in  vector FIFO write enable / data
//   abort             only with MAT_VEC_LOADER_ABORT_EN defined
//
// Macro MAT_VEC_LOADER_ABORT_EN adds the abort input.
module mat_vec_loader #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef MAT_VEC_LOADER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  Clr,
  output logic                  a_wren    [DEPTH],
  output logic [DATA_WIDTH-1:0] a_fifo_in [DEPTH],
  output logic                  b_wren,
  output logic [DATA_WIDTH-1:0] b_fifo_in
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         bidx_q, bidx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  clr_q, clr_d;
  logic                  a_wren_q    [DEPTH];
  logic                  a_wren_d    [DEPTH];
  logic [DATA_WIDTH-1:0] a_fifo_in_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_fifo_in_d [DEPTH];
  logic                  b_wren_q, b_wren_d;
  logic [DATA_WIDTH-1:0] b_fifo_in_q, b_fifo_in_d;
  logic                  xfer;

  // Next state, counters and next output values.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    bidx_d      = bidx_q;
    a_fifo_in_d = a_fifo_in_q;
    b_fifo_in_d = b_fifo_in_q;
    b_wren_d    = 1'b0;
    for (int r = 0; r < DEPTH; r++) a_wren_d[r] = 1'b0;
    xfer = in_valid && in_ready_q;

    case (state_q)
      IDLE: if (start) state_d = CLEAR;
      CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        bidx_d  = '0;
        state_d = LOAD_A;
      end
      LOAD_A: if (xfer) begin
        a_wren_d[row_q]    = 1'b1;
        a_fifo_in_d[row_q] = in_data;
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            row_d   = '0;
            state_d = LOAD_B;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      LOAD_B: if (xfer) begin
        b_wren_d    = 1'b1;
        b_fifo_in_d = in_data;
        if (bidx_q == LAST) begin
          bidx_d  = '0;
          state_d = DONE;
        end else begin
          bidx_d = bidx_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    busy_d     = (state_d == CLEAR) || in_ready_d;
    done_d     = (state_d == DONE);
    clr_d      = (state_d != CLEAR);

`ifdef MAT_VEC_LOADER_ABORT_EN
    // Abort drops any write in flight and clears the multiplier on the way out.
    if (abort && busy_q) begin
      state_d     = IDLE;
      row_d       = '0;
      col_d       = '0;
      bidx_d      = '0;
      a_fifo_in_d = a_fifo_in_q;
      b_fifo_in_d = b_fifo_in_q;
      b_wren_d    = 1'b0;
      for (int r = 0; r < DEPTH; r++) a_wren_d[r] = 1'b0;
      in_ready_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      clr_d       = 1'b0;
    end
`endif
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      bidx_q      <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_q       <= 1'b1;
      b_wren_q    <= 1'b0;
      b_fifo_in_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        a_wren_q[r]    <= 1'b0;
        a_fifo_in_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      bidx_q      <= bidx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clr_q       <= clr_d;
      b_wren_q    <= b_wren_d;
      b_fifo_in_q <= b_fifo_in_d;
      for (int r = 0; r < DEPTH; r++) begin
        a_wren_q[r]    <= a_wren_d[r];
        a_fifo_in_q[r] <= a_fifo_in_d[r];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign Clr       = clr_q;
  assign a_wren    = a_wren_q;
  assign a_fifo_in = a_fifo_in_q;
  assign b_wren    = b_wren_q;
  assign b_fifo_in = b_fifo_in_q;

endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench for mat_vec_loader: the driver pushes expected FIFO writes
// into queues, the negedge monitor pops and compares every write it sees.
module tb_mat_vec_loader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  typedef struct packed {
    logic [2:0]    row;
    logic [DW-1:0] data;
  } a_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
`ifdef MAT_VEC_LOADER_ABORT_EN
  logic          abort;
`endif
  logic          in_ready, busy, done, Clr, b_wren;
  logic          a_wren    [DEPTH];
  logic [DW-1:0] a_fifo_in [DEPTH];
  logic [DW-1:0] b_fifo_in;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;
  int rdy_cnt  = 0;

  a_exp_t        a_q[$];
  logic [DW-1:0] b_q[$];

  mat_vec_loader #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MAT_VEC_LOADER_ABORT_EN
    .abort     (abort),
`endif
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .Clr       (Clr),
    .a_wren    (a_wren),
    .a_fifo_in (a_fifo_in),
    .b_wren    (b_wren),
    .b_fifo_in (b_fifo_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every FIFO write against the scoreboard queues.
  always @(negedge clk) begin
    int     nw;
    a_exp_t e;
    logic [DW-1:0] eb;
    if (rst_n) begin
      nw = 0;
      for (int r = 0; r < DEPTH; r++) begin
        if (a_wren[r]) begin
          nw++;
          if (a_q.size() == 0) begin
            chk("a_extra_write", r, -1);
          end else begin
            e = a_q.pop_front();
            chk("a_row", r, int'(e.row));
            chk("a_data", int'(a_fifo_in[r]), int'(e.data));
          end
        end
      end
      if (nw > 1) chk("a_wren_onehot", nw, 1);
      if (b_wren) begin
        if (b_q.size() == 0) begin
          chk("b_extra_write", int'(b_fifo_in), -1);
        end else begin
          eb = b_q.pop_front();
          chk("b_data", int'(b_fifo_in), int'(eb));
        end
      end
      if (done)     done_cnt++;
      if (!Clr)     clr_cnt++;
      if (in_ready) rdy_cnt++;
    end
  end

  // Present one element once in_ready is up; optional one idle in_ready cycle first.
  task automatic send(input logic [DW-1:0] v, input int row, input bit gap);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      if (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      if (row >= 0) a_q.push_back(a_exp_t'{3'(row), v});
      else          b_q.push_back(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_all(input logic [DW-1:0] base, input int cnt, input bit gap);
    for (int k = 0; k < cnt; k++)
      send(base + DW'(k), (k < DEPTH * DEPTH) ? k / DEPTH : -1, gap);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic end_checks(input string tag, input int d0, input int c0, input int r0,
                            input int exp_rdy);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_clr_cycles"}, clr_cnt - c0, 1);
    chk({tag, "_ready_cycles"}, rdy_cnt - r0, exp_rdy);
    chk({tag, "_a_pending"}, a_q.size(), 0);
    chk({tag, "_b_pending"}, b_q.size(), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_Clr"}, int'(Clr), 1);
    chk({tag, "_b_wren"}, int'(b_wren), 0);
    chk({tag, "_b_fifo_in"}, int'(b_fifo_in), 0);
    for (int r = 0; r < DEPTH; r++) begin
      chk({tag, "_a_wren"}, int'(a_wren[r]), 0);
      chk({tag, "_a_fifo_in"}, int'(a_fifo_in[r]), 0);
    end
  endtask

  initial begin
    int d0, c0, r0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef MAT_VEC_LOADER_ABORT_EN
    abort    = 1'b0;
`endif
    #23;
    reset_checks("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back load of 0x00..0x47.
    d0 = done_cnt; c0 = clr_cnt; r0 = rdy_cnt;
    pulse_start();
    chk("busy_in_clear", int'(busy), 1);
    chk("clr_low_in_clear", int'(Clr), 0);
    send_all(8'h00, 72, 1'b0);
    wait_done(d0);
    end_checks("b2b", d0, c0, r0, 72);
    chk("b2b_last_row0", int'(a_fifo_in[0]), 8'h07);
    chk("b2b_last_row7", int'(a_fifo_in[7]), 8'h3F);
    chk("b2b_last_b", int'(b_fifo_in), 8'h47);

    // in_valid alternating 0/1: same contents, 144 loading cycles.
    d0 = done_cnt; c0 = clr_cnt; r0 = rdy_cnt;
    pulse_start();
    send_all(8'h00, 72, 1'b1);
    wait_done(d0);
    end_checks("toggle", d0, c0, r0, 144);

    // start held through the whole sequence including the DONE cycle.
    d0 = done_cnt; c0 = clr_cnt; r0 = rdy_cnt;
    @(negedge clk);
    start = 1'b1;
    send_all(8'h10, 72, 1'b0);
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("held_done_seen", int'(done), 1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    end_checks("held", d0, c0, r0, 72);

    // Asynchronous reset after 20 transfers, then a clean restart.
    pulse_start();
    send_all(8'h00, 20, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    chk("midrst_a_pending", a_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt; c0 = clr_cnt; r0 = rdy_cnt;
    pulse_start();
    send_all(8'h80, 72, 1'b0);
    wait_done(d0);
    end_checks("restart", d0, c0, r0, 72);
    chk("restart_row0", int'(a_fifo_in[0]), 8'h87);

`ifdef MAT_VEC_LOADER_ABORT_EN
    // Abort after 65 transfers: IDLE next cycle, one Clr low cycle, no done.
    d0 = done_cnt;
    pulse_start();
    c0 = clr_cnt;
    send_all(8'h00, 65, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_clr_low", int'(Clr), 0);
    @(posedge clk);
    #1;
    chk("abort_clr_high", int'(Clr), 1);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_clr_cycles", clr_cnt - c0, 1);
    chk("abort_a_pending", a_q.size(), 0);
    chk("abort_b_pending", b_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
